// File: rtl/turf_ethernet_pkg.sv
// Shared field layout and grant encoding for the TURF ack/nack path.
//   ALLOW_BIT  : bit position of the allow/ack flag in a 16-bit beat
//   ADDR_BITS  : width of the address field at the bottom of a beat
//   grant_e    : round-robin grant encoding (ACK=0, NACK=1)
//   merge_beat : builds a merged output beat from a source flag and input data
package turf_ethernet_pkg;

  localparam int unsigned ALLOW_BIT = 15;
  localparam int unsigned ADDR_BITS = 12;
  localparam int unsigned BEAT_BITS = 16;

  typedef enum logic {
    GRANT_ACK  = 1'b0,
    GRANT_NACK = 1'b1
  } grant_e;

  // Input bit 15 is discarded; the source port alone decides ack vs nack.
  function automatic logic [BEAT_BITS-1:0] merge_beat(input logic                 is_ack,
                                                      input logic [BEAT_BITS-1:0] in_data);
    logic [BEAT_BITS-1:0] beat;
    beat                 = '0;
    beat[ADDR_BITS-1:0]  = in_data[ADDR_BITS-1:0];
    beat[ALLOW_BIT]      = is_ack;
    return beat;
  endfunction

endpackage

// File: rtl/turf_rr_arb2.sv
// Two-input round-robin arbiter with a registered last-grant bit.
//   clk, rst     : clock and asynchronous active-high reset
//   en_i         : grants may be issued this cycle (downstream can load)
//   req_ack_i    : ack input has a beat
//   req_nack_i   : nack input has a beat
//   gnt_ack_o    : ack input is granted (doubles as its ready)
//   gnt_nack_o   : nack input is granted (doubles as its ready)
module turf_rr_arb2
  import turf_ethernet_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_ack_i,
  input  logic req_nack_i,
  output logic gnt_ack_o,
  output logic gnt_nack_o
);

  grant_e last_grant_q, last_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_ACK;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // A grant is only issued to a requesting input while enabled, so every
  // grant is a completed handshake and may update last_grant directly.
  always_comb begin
    gnt_ack_o    = 1'b0;
    gnt_nack_o   = 1'b0;
    last_grant_d = last_grant_q;
    if (en_i) begin
      if (req_ack_i && req_nack_i) begin
        if (last_grant_q == GRANT_ACK) gnt_nack_o = 1'b1;
        else                           gnt_ack_o  = 1'b1;
      end else if (req_ack_i) begin
        gnt_ack_o = 1'b1;
      end else if (req_nack_i) begin
        gnt_nack_o = 1'b1;
      end
    end
    if (gnt_ack_o)       last_grant_d = GRANT_ACK;
    else if (gnt_nack_o) last_grant_d = GRANT_NACK;
  end

endmodule

// File: rtl/turf_acknack_merge.sv
// Merges the ack and nack AXI-Stream ports into one registered stream and
// counts forwarded acks/nacks.
//   aclk, areset          : clock, asynchronous active-high reset
//   clear_i               : synchronous clear of both counters
//   s_ack_*               : ack input stream (tdata[11:0] addr)
//   s_nack_*              : nack input stream (tdata[11:0] addr)
//   m_acknack_*           : merged output; tdata[15]=1 ack / 0 nack
//   ack_count_o           : acks delivered on the output
//   nack_count_o          : nacks delivered on the output
module turf_acknack_merge
  import turf_ethernet_pkg::*;
#(
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  clear_i,
  input  logic                  s_ack_tvalid,
  output logic                  s_ack_tready,
  input  logic [BEAT_BITS-1:0]  s_ack_tdata,
  input  logic                  s_nack_tvalid,
  output logic                  s_nack_tready,
  input  logic [BEAT_BITS-1:0]  s_nack_tdata,
  output logic                  m_acknack_tvalid,
  input  logic                  m_acknack_tready,
  output logic [BEAT_BITS-1:0]  m_acknack_tdata,
  output logic [COUNT_BITS-1:0] ack_count_o,
  output logic [COUNT_BITS-1:0] nack_count_o
);

  logic                  valid_q, valid_d;
  logic [BEAT_BITS-1:0]  data_q, data_d;
  logic [COUNT_BITS-1:0] ack_cnt_q, ack_cnt_d;
  logic [COUNT_BITS-1:0] nack_cnt_q, nack_cnt_d;
  logic                  load;
  logic                  arb_en;
  logic                  out_hs;

  assign load   = !valid_q || m_acknack_tready;
  // Readies must stay low while reset is held even though the empty output
  // register would otherwise permit a load.
  assign arb_en = load && !areset;
  assign out_hs = valid_q && m_acknack_tready;

  turf_rr_arb2 u_arb (
    .clk        (aclk),
    .rst        (areset),
    .en_i       (arb_en),
    .req_ack_i  (s_ack_tvalid),
    .req_nack_i (s_nack_tvalid),
    .gnt_ack_o  (s_ack_tready),
    .gnt_nack_o (s_nack_tready)
  );

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    ack_cnt_d  = ack_cnt_q;
    nack_cnt_d = nack_cnt_q;
    if (load) begin
      valid_d = s_ack_tready || s_nack_tready;
      if (s_ack_tready)       data_d = merge_beat(1'b1, s_ack_tdata);
      else if (s_nack_tready) data_d = merge_beat(1'b0, s_nack_tdata);
    end
    if (clear_i) begin
      ack_cnt_d  = '0;
      nack_cnt_d = '0;
    end else if (out_hs) begin
      if (data_q[ALLOW_BIT]) ack_cnt_d  = ack_cnt_q + 1'b1;
      else                   nack_cnt_d = nack_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      ack_cnt_q  <= '0;
      nack_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      ack_cnt_q  <= ack_cnt_d;
      nack_cnt_q <= nack_cnt_d;
    end
  end

  assign m_acknack_tvalid = valid_q;
  assign m_acknack_tdata  = data_q;
  assign ack_count_o      = ack_cnt_q;
  assign nack_count_o     = nack_cnt_q;

endmodule

// File: tb/tb_turf_acknack_merge.sv
module tb_turf_acknack_merge;

  localparam int unsigned CB = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          clear_i = 1'b0;
  logic          s_ack_tvalid = 1'b0;
  logic          s_ack_tready;
  logic [15:0]   s_ack_tdata = '0;
  logic          s_nack_tvalid = 1'b0;
  logic          s_nack_tready;
  logic [15:0]   s_nack_tdata = '0;
  logic          m_acknack_tvalid;
  logic          m_acknack_tready = 1'b1;
  logic [15:0]   m_acknack_tdata;
  logic [CB-1:0] ack_count_o;
  logic [CB-1:0] nack_count_o;

  turf_acknack_merge #(.COUNT_BITS(CB)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .clear_i          (clear_i),
    .s_ack_tvalid     (s_ack_tvalid),
    .s_ack_tready     (s_ack_tready),
    .s_ack_tdata      (s_ack_tdata),
    .s_nack_tvalid    (s_nack_tvalid),
    .s_nack_tready    (s_nack_tready),
    .s_nack_tdata     (s_nack_tdata),
    .m_acknack_tvalid (m_acknack_tvalid),
    .m_acknack_tready (m_acknack_tready),
    .m_acknack_tdata  (m_acknack_tdata),
    .ack_count_o      (ack_count_o),
    .nack_count_o     (nack_count_o)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ack_q[$];
  logic [15:0] nack_q[$];
  logic [15:0] exp_q[$];

  logic ack_fire = 1'b0;
  logic nack_fire = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample handshakes half a cycle before the edge that completes them.
  initial forever begin
    @(negedge aclk);
    ack_fire  = s_ack_tvalid && s_ack_tready;
    nack_fire = s_nack_tvalid && s_nack_tready;
  end

  // Scoreboard monitor: every output beat must match the next expected beat.
  initial forever begin
    @(negedge aclk);
    if (m_acknack_tvalid && m_acknack_tready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h expected none at %0t", m_acknack_tdata, $time);
      end else begin
        chk("out_beat", {16'h0, m_acknack_tdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Source drivers: present the queue head, advance after a handshake.
  initial forever begin
    @(posedge aclk);
    #1;
    if (ack_fire && ack_q.size() > 0)   void'(ack_q.pop_front());
    if (nack_fire && nack_q.size() > 0) void'(nack_q.pop_front());
    ack_fire  = 1'b0;
    nack_fire = 1'b0;
    s_ack_tvalid  = (ack_q.size() > 0);
    s_ack_tdata   = (ack_q.size() > 0) ? ack_q[0] : 16'h0;
    s_nack_tvalid = (nack_q.size() > 0);
    s_nack_tdata  = (nack_q.size() > 0) ? nack_q[0] : 16'h0;
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic drain(input string name, input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge aclk);
      #1;
      if (exp_q.size() == 0 && ack_q.size() == 0 && nack_q.size() == 0 && !m_acknack_tvalid) begin
        done = 1;
        break;
      end
    end
    if (!done) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  initial begin
    int cyc;
    bit seen;

    // Reset state, with an ack already waiting at the input.
    ack_q.push_back(16'h0123);
    exp_q.push_back(16'h8123);
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", {31'h0, m_acknack_tvalid}, 32'h0);
    chk("rst_tdata", {16'h0, m_acknack_tdata}, 32'h0);
    chk("rst_ack_tready", {31'h0, s_ack_tready}, 32'h0);
    chk("rst_nack_tready", {31'h0, s_nack_tready}, 32'h0);
    chk("rst_ack_cnt", {28'h0, ack_count_o}, 32'h0);
    chk("rst_nack_cnt", {28'h0, nack_count_o}, 32'h0);
    step();
    areset = 1'b0;
    drain("single_ack", 20);
    chk("single_ack_cnt", {28'h0, ack_count_o}, 32'h1);

    // Single nack with bit 15 set on input.
    step();
    nack_q.push_back(16'h8ABC);
    exp_q.push_back(16'h0ABC);
    drain("single_nack", 20);
    chk("single_nack_cnt", {28'h0, nack_count_o}, 32'h1);

    // Backpressure for 5 cycles, then release together with a counter clear.
    step();
    m_acknack_tready = 1'b0;
    ack_q.push_back(16'h0055);
    ack_q.push_back(16'h0066);
    exp_q.push_back(16'h8055);
    exp_q.push_back(16'h8066);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (m_acknack_tvalid) begin
        seen = 1;
        break;
      end
    end
    chk("bp_loaded", {31'h0, seen}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_tvalid", {31'h0, m_acknack_tvalid}, 32'h1);
      chk("bp_tdata", {16'h0, m_acknack_tdata}, 32'h8055);
      chk("bp_ack_tready", {31'h0, s_ack_tready}, 32'h0);
      chk("bp_nack_tready", {31'h0, s_nack_tready}, 32'h0);
      @(negedge aclk);
    end
    step();
    m_acknack_tready = 1'b1;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    @(negedge aclk);
    chk("clear_ack_cnt", {28'h0, ack_count_o}, 32'h0);
    chk("clear_nack_cnt", {28'h0, nack_count_o}, 32'h0);
    drain("bp", 20);
    chk("post_clear_ack_cnt", {28'h0, ack_count_o}, 32'h1);

    // Wrap: 17 acks on a 4-bit counter leave it at 1.
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ack_q.push_back(16'h0200 + 16'(i));
      exp_q.push_back(16'h8200 + 16'(i));
    end
    drain("wrap", 60);
    chk("wrap_ack_cnt", {28'h0, ack_count_o}, 32'h1);

    // Reset while a beat sits in the output register: it is dropped.
    step();
    m_acknack_tready = 1'b0;
    ack_q.push_back(16'h0077);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (m_acknack_tvalid) begin
        seen = 1;
        break;
      end
    end
    chk("mid_loaded", {31'h0, seen}, 32'h1);
    step();
    areset = 1'b1;
    #1;
    chk("mid_rst_tvalid", {31'h0, m_acknack_tvalid}, 32'h0);
    chk("mid_rst_ack_cnt", {28'h0, ack_count_o}, 32'h0);
    m_acknack_tready = 1'b1;

    // Contention straight after reset: NACK first, then alternating.
    for (int i = 0; i < 4; i++) begin
      ack_q.push_back(16'h8001 + 16'(i));
      nack_q.push_back(16'h0100 + 16'(i));
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      exp_q.push_back(16'h8001 + 16'(i));
    end
    repeat (3) @(negedge aclk);
    chk("cont_rst_ack_tready", {31'h0, s_ack_tready}, 32'h0);
    chk("cont_rst_nack_tready", {31'h0, s_nack_tready}, 32'h0);
    step();
    areset = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge aclk);
      #1;
      if (exp_q.size() == 0) begin
        cyc = i;
        break;
      end
    end
    chk("cont_cycles", cyc, 32'd9);
    drain("cont", 20);
    chk("cont_ack_cnt", {28'h0, ack_count_o}, 32'h4);
    chk("cont_nack_cnt", {28'h0, nack_count_o}, 32'h4);
    chk("exp_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/turf_acknack_merge.md
TURF_ACKNACK_MERGE -- requirements
Module: turf_acknack_merge

Interface
REQ-001 SHALL have parameter COUNT_BITS, default 16, width of the ack/nack event counters.
REQ-002 SHALL have port aclk  input  1  sole clock; all logic is on its rising edge.
REQ-003 SHALL have port areset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port clear_i  input  1  synchronous counter clear.
REQ-005 SHALL have ports s_ack_tvalid/tready/tdata  in/out/in  1/1/16  ack stream from the ack port; tdata[15] allow, tdata[11:0] addr.
REQ-006 SHALL have ports s_nack_tvalid/tready/tdata  in/out/in  1/1/16  nack stream from the nack port; same field layout.
REQ-007 SHALL have ports m_acknack_tvalid/tready/tdata  out/in/out  1/1/16  merged stream to the frame buffer.
REQ-008 SHALL have port ack_count_o  output  COUNT_BITS  number of acks forwarded.
REQ-009 SHALL have port nack_count_o  output  COUNT_BITS  number of nacks forwarded.

Function
REQ-010 SHALL drive each merged beat as follows: tdata[15] = 1 for an ack, 0 for a nack (input bit 15 is ignored); tdata[11:0] = input addr; tdata[14:12] = 0.
REQ-011 SHALL register the output: a beat accepted on an input appears on m_acknack_ on the next cycle (1-cycle latency).
REQ-012 SHALL load the output register only when (!m_acknack_tvalid || m_acknack_tready), i.e. when it is empty or being drained this cycle.
REQ-013 SHALL assert at most one of s_ack_tready and s_nack_tready in any cycle.
REQ-014 SHALL assert that one ready only in a cycle where the output register loads and the granted input is valid, so no beat is lost or duplicated.
REQ-015 SHALL arbitrate round-robin using a 1-bit last_grant register (ACK=0, NACK=1).
- If both inputs are valid, grant the input not equal to last_grant.
- If only one input is valid, grant it.
REQ-016 SHALL update last_grant only on a completed input handshake.
REQ-017 SHALL sustain full throughput: with m_acknack_tready held high and an input valid, one beat per cycle.
REQ-018 SHALL hold m_acknack_tdata stable while m_acknack_tvalid=1 and m_acknack_tready=0.
REQ-019 SHALL increment ack_count_o / nack_count_o on each output handshake whose beat is an ack / nack respectively.
REQ-020 SHALL let the counters wrap modulo 2^COUNT_BITS.
REQ-021 SHALL give clear_i priority over an increment in the same cycle: the counter reads 0 on the next cycle and that beat is not counted.
REQ-022 SHALL not let clear_i affect the data path or the arbitration state.
REQ-023 SHALL accept no input beat while m_acknack_tvalid=1 and m_acknack_tready=0 (both readies low).

Reset
REQ-024 SHALL, while areset=1, hold m_acknack_tvalid=0, m_acknack_tdata=0, both s_*_tready=0, both counters=0 and last_grant=ACK, so NACK wins the first contention.
REQ-025 SHALL discard an in-flight output beat when reset is asserted mid-operation; the beat is not replayed after reset.
REQ-026 SHALL accept inputs no earlier than the first aclk edge after areset deasserts.

Structure
REQ-027 SHALL take the field constants (ALLOW_BIT=15, ADDR_BITS=12) and the grant encoding from the shared package turf_ethernet_pkg.
REQ-028 SHALL be implemented as a single module containing one sub-module, turf_rr_arb2 (a 2-input round-robin arbiter, combinational grant plus last_grant register).

Verification
REQ-029 SHALL cover: single ack, tdata=16'h0123 on s_ack_, m_acknack_tready=1 -> next cycle m_acknack_tdata=16'h8123, ack_count_o=1.
REQ-030 SHALL cover: single nack, tdata=16'h8ABC on s_nack_ -> m_acknack_tdata=16'h0ABC, nack_count_o=1.
REQ-031 SHALL cover contention: both inputs valid continuously after reset (ack addr 0x001.., nack addr 0x100..), tready=1 -> output order N,A,N,A at 1 beat/cycle.
REQ-032 SHALL cover backpressure: m_acknack_tready=0 for 5 cycles with an ack pending.
- m_acknack_tvalid and tdata stay stable and both s_*_tready stay 0.
- On release the beat is delivered exactly once.
REQ-033 SHALL cover counter clear: clear_i asserted in the same cycle as an ack handshake -> ack_count_o=0 next cycle; with COUNT_BITS=4, 17 acks -> ack_count_o=1.
REQ-034 SHALL cover reset mid-stream: areset asserted while m_acknack_tvalid=1 -> tvalid low immediately (asynchronous), counters 0, next contention grants NACK first.
